writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 100 ++++++++++
 tb/tb_writeback_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one of NUM_CH valid channels (fixed, round-robin
// or forced policy) and loads it into a single registered output stage.
module writeback_arbiter #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_BITS    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic [CH_BITS-1:0]           sel,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic [CH_BITS-1:0]           out_ch,
  input  logic                         out_ready
);

  localparam logic [1:0] MODE_RR     = 2'b01;
  localparam logic [1:0] MODE_FORCED = 2'b10;

  logic [CH_BITS-1:0]    rr_ptr;
  logic [CH_BITS-1:0]    rr_next;
  logic [NUM_CH-1:0]     elig;
  logic [CH_BITS-1:0]    start;
  logic [CH_BITS-1:0]    cand;
  logic                  grant_valid;
  logic [CH_BITS-1:0]    grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  load_en;

  assign load_en = !out_valid || out_ready;
  assign rr_next = CH_BITS'((32'(grant_idx) + 32'd1) % NUM_CH);

  // Eligibility mask and search start per policy, then a circular first-valid search.
  always_comb begin : grant_search
    elig        = '0;
    start       = '0;
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    case (mode)
      MODE_RR: begin
        elig  = in_valid;
        start = rr_ptr;
      end
      MODE_FORCED: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          elig[i] = in_valid[i] && (32'(sel) == i);
        end
      end
      default: elig = in_valid;
    endcase
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      cand = CH_BITS'((32'(start) + off) % NUM_CH);
      if (!grant_valid && elig[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Data mux and one-hot ready; ready is held low during reset and stall.
  always_comb begin : grant_route
    grant_data = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_BITS'(i)) begin
        grant_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        in_ready[i] = grant_valid && load_en && rst_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : out_stage
    if (!rst_n) begin
      out_valid  <= 1'b0;
      write_data <= '0;
      out_ch     <= '0;
    end else if (load_en) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        write_data <= grant_data;
        out_ch     <= grant_idx;
      end
    end
  end

  // Pointer advances only on an accepted round-robin transfer.
  always_ff @(posedge clk or negedge rst_n) begin : rr_state
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (load_en && grant_valid && (mode == MODE_RR)) begin
      rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized checks for writeback_arbiter (NUM_CH=4, DATA_WIDTH=4).
module tb_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  write_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int errors;
  int checks;

  writeback_arbiter #(.DATA_WIDTH(4), .NUM_CH(4), .CH_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .write_data(write_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int exp_grant(input logic [1:0] m, input logic [3:0] v,
                                   input int sl, input int ptr);
    int c;
    if (m == 2'b10) return (sl < 4 && v[2'(sl)]) ? sl : -1;
    for (int k = 0; k < 4; k++) begin
      c = (m == 2'b01) ? (ptr + k) % 4 : k;
      if (v[2'(c)]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; sel = 2'd0; in_valid = 4'b1111;
    in_data = 16'hFFFF; out_ready = 1'b1;
    #12;
    checks++;
    if ({out_valid, out_ch, write_data} !== 7'd0) begin
      errors++;
      $display("FAIL reset_regs: got %b expected 0000000", {out_valid, out_ch, write_data});
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b0000;
  endtask

  task automatic test_fixed();
    mode = 2'b00; in_valid = 4'b1010; in_data = 16'h9050; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL fixed_ready: got %b expected 0010", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_ch, write_data} !== {1'b1, 2'd1, 4'd5}) begin
      errors++; $display("FAIL fixed_out: got %b expected 1015", {out_valid, out_ch, write_data});
    end
    mode = 2'b11; in_valid = 4'b1100; in_data = 16'hA300;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++; $display("FAIL mode11_ready: got %b expected 0100", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_ch, write_data} !== {1'b1, 2'd2, 4'd3}) begin
      errors++; $display("FAIL mode11_out: got %b expected 1_10_0011", {out_valid, out_ch, write_data});
    end
    in_valid = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL idle_ready: got %b expected 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ir;
    mode = 2'b01; in_valid = 4'b1111; in_data = 16'hDCBA; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_ir = 4'(1 << (k % 4));
      checks++;
      if (in_ready !== exp_ir) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, exp_ir);
      end
      tick();
      checks++;
      if ({out_valid, out_ch, write_data} !== {1'b1, 2'(k % 4), 4'(10 + k % 4)}) begin
        errors++;
        $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 k, out_valid, out_ch, write_data, k % 4, 4'(10 + k % 4));
      end
    end
    in_valid = 4'b1001;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL rr_skip_ready: got %b expected 1000", in_ready);
    end
    tick();
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_wrap_ready: got %b expected 0001", in_ready);
    end
    checks++;
    if ({out_ch, write_data} !== {2'd3, 4'hD}) begin
      errors++; $display("FAIL rr_skip_out: got ch=%0d d=%h expected ch=3 d=d", out_ch, write_data);
    end
    tick();
    checks++;
    if ({out_valid, out_ch, write_data} !== {1'b1, 2'd0, 4'hA}) begin
      errors++; $display("FAIL rr_wrap_out: got ch=%0d d=%h expected ch=0 d=a", out_ch, write_data);
    end
  endtask

  task automatic test_stall();
    mode = 2'b00; in_valid = 4'b0100; in_data = 16'h0700; out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_ch, write_data} !== {1'b1, 2'd2, 4'd7}) begin
      errors++; $display("FAIL stall_load: got ch=%0d d=%h expected ch=2 d=7", out_ch, write_data);
    end
    in_valid = 4'b0001; in_data = 16'h0704; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL stall_ready[%0d]: got %b expected 0000", k, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_ch, write_data} !== {1'b1, 2'd2, 4'd7}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=2 d=7",
                 k, out_valid, out_ch, write_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL stall_release_ready: got %b expected 0001", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_ch, write_data} !== {1'b1, 2'd0, 4'd4}) begin
      errors++; $display("FAIL stall_release_out: got ch=%0d d=%h expected ch=0 d=4", out_ch, write_data);
    end
  endtask

  task automatic test_forced();
    mode = 2'b10; sel = 2'd3; in_valid = 4'b0111; in_data = 16'h0654; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL forced_none_ready: got %b expected 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL forced_drain: got out_valid=%b expected 0", out_valid);
    end
    sel = 2'd1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL forced_sel1_ready: got %b expected 0010", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_ch, write_data} !== {1'b1, 2'd1, 4'd5}) begin
      errors++; $display("FAIL forced_sel1_out: got ch=%0d d=%h expected ch=1 d=5", out_ch, write_data);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'b01; in_valid = 4'b0100; in_data = 16'h0800; out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_ch, write_data} !== {1'b1, 2'd2, 4'd8}) begin
      errors++; $display("FAIL rstmid_pre: got ch=%0d d=%h expected ch=2 d=8", out_ch, write_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_ch, write_data} !== 7'd0) begin
      errors++; $display("FAIL rstmid_regs: got %b expected 0000000", {out_valid, out_ch, write_data});
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL rstmid_ready: got %b expected 0000", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b1111; in_data = 16'h4321;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL rstmid_rr_ready: got %b expected 0001", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_ch, write_data} !== {1'b1, 2'd0, 4'd1}) begin
      errors++; $display("FAIL rstmid_rr_out: got ch=%0d d=%h expected ch=0 d=1", out_ch, write_data);
    end
  endtask

  task automatic test_random();
    logic [5:0] sb[$];
    logic [5:0] front;
    logic [3:0] exp_ir;
    logic [3:0] g_data;
    logic       m_ov;
    logic       mload;
    int         ptr;
    int         g;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    m_ov = 1'b0; ptr = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      mode = 2'($urandom_range(0, 3));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      in_data = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = exp_grant(mode, in_valid, int'(sel), ptr);
      mload = !m_ov || out_ready;
      exp_ir = (g >= 0 && mload) ? 4'(1 << g) : 4'b0000;
      g_data = (g >= 0) ? 4'(in_data >> (g * 4)) : 4'h0;
      checks++;
      if (in_ready !== exp_ir) begin
        errors++; $display("FAIL rand_ready @%0d: got %b expected %b", cyc, in_ready, exp_ir);
      end
      checks++;
      if (out_valid !== m_ov) begin
        errors++; $display("FAIL rand_out_valid @%0d: got %b expected %b", cyc, out_valid, m_ov);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_dup @%0d: output ch=%0d d=%h with nothing accepted", cyc, out_ch, write_data);
        end else begin
          front = sb.pop_front();
          if ({out_ch, write_data} !== front) begin
            errors++;
            $display("FAIL rand_order @%0d: got ch=%0d d=%h expected ch=%0d d=%h",
                     cyc, out_ch, write_data, front[5:4], front[3:0]);
          end
        end
      end
      if (mload) begin
        m_ov = (g >= 0);
        if (g >= 0) begin
          sb.push_back({2'(g), g_data});
          if (mode == 2'b01) ptr = (g + 1) % 4;
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != (m_ov ? 1 : 0)) begin
      errors++; $display("FAIL rand_leftover: got %0d queued expected %0d", sb.size(), m_ov ? 1 : 0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_stall();
    test_forced();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
